// File: rtl/rst_seq_ctrl_if.sv
// Reset request / sequenced reset output bundle for rst_seq_ctrl.
// master drives the requests and observes the resets; slave is the sequencer.
interface rst_seq_ctrl_if #(
    parameter int NUM_OUT = 4
);
    logic               rst_req_n;
    logic               sw_rst;
    logic [NUM_OUT-1:0] rst_out;
    logic               seq_done;
    logic [1:0]         rst_cause;

    modport master (
        output rst_req_n, sw_rst,
        input  rst_out, seq_done, rst_cause
    );

    modport slave (
        input  rst_req_n, sw_rst,
        output rst_out, seq_done, rst_cause
    );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all reset outputs low while a request is present, then
// releases them one by one (bit 0 first) after a hold period.
module rst_seq_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_OUT     = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    rst_seq_ctrl_if.slave bus
);
    localparam logic [1:0] ST_ASSERT  = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam int CNT_MAX = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int IW      = $clog2(NUM_OUT + 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NUM_OUT-1:0]     out_q, out_d;
    logic                   done_q, done_d;
    logic [1:0]             cause_q, cause_d;
    logic                   req_sync, req;
    logic [1:0]             cause_now;

    // RST_REQ_N enters at stage 0; only the last stage is ever looked at.
    assign sync_d    = {sync_q[SYNC_STAGES-2:0], bus.rst_req_n};
    assign req_sync  = sync_q[SYNC_STAGES-1];
    assign req       = !req_sync || bus.sw_rst;
    assign cause_now = {bus.sw_rst, !req_sync};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        out_d   = out_q;
        done_d  = done_q;
        cause_d = cause_q;
        if (req) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            out_d   = '0;
            done_d  = 1'b0;
            // Fresh cause on entry, accumulate while the request persists.
            cause_d = (state_q == ST_ASSERT) ? (cause_q | cause_now) : cause_now;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
                ST_HOLD: begin
                    if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                        out_d[0] = 1'b1;
                        cnt_d    = '0;
                        idx_d    = IW'(1);
                        if (NUM_OUT == 1) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == CW'(STEP_CYCLES - 1)) begin
                        cnt_d = '0;
                        for (int i = 0; i < NUM_OUT; i++) begin
                            if (int'(idx_q) == i) out_d[i] = 1'b1;
                        end
                        if (idx_q == IW'(NUM_OUT - 1)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_DONE: ;
                default: state_d = ST_ASSERT;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            cause_q <= 2'b01;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            done_q  <= done_d;
            cause_q <= cause_d;
        end
    end

    assign bus.rst_out   = out_q;
    assign bus.seq_done  = done_q;
    assign bus.rst_cause = cause_q;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: expected outputs are queued with the edge
// they belong to and compared as the run reaches that edge.
module tb_rst_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rst_seq_ctrl_if #(.NUM_OUT(4)) b1();
    rst_seq_ctrl_if #(.NUM_OUT(1)) b2();

    rst_seq_ctrl #(.SYNC_STAGES(2), .NUM_OUT(4), .HOLD_CYCLES(16), .STEP_CYCLES(4)) u_dut (
        .clk_i(clk), .rst_i(rst), .bus(b1.slave)
    );
    rst_seq_ctrl #(.SYNC_STAGES(2), .NUM_OUT(1), .HOLD_CYCLES(1), .STEP_CYCLES(4)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .bus(b2.slave)
    );

    typedef struct {
        string      tag;
        int         e;
        bit         which;
        logic [6:0] exp;   // {rst_out[3:0], seq_done, rst_cause}
    } item_t;

    item_t q[$];
    int    ecnt = 0;
    int    vecs = 0;
    int    errs = 0;

    function automatic logic [6:0] observe(bit which);
        if (which) return {3'b000, b2.rst_out, b2.seq_done, b2.rst_cause};
        return {b1.rst_out, b1.seq_done, b1.rst_cause};
    endfunction

    task automatic push(input string tag, input int e, input bit which,
                        input logic [3:0] o, input logic d, input logic [1:0] c);
        item_t it;
        it.tag = tag; it.e = e; it.which = which; it.exp = {o, d, c};
        q.push_back(it);
    endtask

    task automatic tick_check();
        item_t      it;
        logic [6:0] obs;
        @(posedge clk);
        ecnt++;
        #1;
        while (q.size() > 0 && q[0].e <= ecnt) begin
            it  = q.pop_front();
            obs = observe(it.which);
            vecs++;
            assert (it.e == ecnt && obs === it.exp) else begin
                errs++;
                $error("FAIL %s @edge %0d: got out/done/cause=%b expected %b (due edge %0d)",
                       it.tag, ecnt, obs, it.exp, it.e);
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 200) begin
            tick_check();
            n++;
        end
        if (q.size() > 0) begin
            vecs++;
            errs++;
            $error("FAIL timeout: %0d expected vectors never reached, got edge %0d", q.size(), ecnt);
            q.delete();
        end
    endtask

    task automatic check_now(input string tag, input bit which, input logic [6:0] exp);
        logic [6:0] obs;
        obs = observe(which);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got out/done/cause=%b expected %b", tag, obs, exp);
        end
    endtask

    int p, a, c;

    initial begin
        b1.rst_req_n = 1'b1; b1.sw_rst = 1'b0;
        b2.rst_req_n = 1'b1; b2.sw_rst = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_now("reset_state", 1'b0, {4'b0000, 1'b0, 2'b01});
        check_now("reset_state_n1", 1'b1, {4'b0000, 1'b0, 2'b01});
        rst  = 1'b0;
        ecnt = 0;

        // Power-on release timing with default parameters and NUM_OUT=1/HOLD=1.
        push("por_e3",      3, 1'b0, 4'b0000, 1'b0, 2'b01);
        push("n1_e3",       3, 1'b1, 4'b0000, 1'b0, 2'b01);
        push("n1_e4",       4, 1'b1, 4'b0001, 1'b1, 2'b01);
        push("por_e18",    18, 1'b0, 4'b0000, 1'b0, 2'b01);
        push("por_b0",     19, 1'b0, 4'b0001, 1'b0, 2'b01);
        push("por_e22",    22, 1'b0, 4'b0001, 1'b0, 2'b01);
        push("por_b1",     23, 1'b0, 4'b0011, 1'b0, 2'b01);
        push("por_b2",     27, 1'b0, 4'b0111, 1'b0, 2'b01);
        push("por_e30",    30, 1'b0, 4'b0111, 1'b0, 2'b01);
        push("por_done",   31, 1'b0, 4'b1111, 1'b1, 2'b01);
        drain();

        // Software reset pulse while DONE; stop once two bits are released.
        p = ecnt + 1;
        push("sw_edge",    p,      1'b0, 4'b0000, 1'b0, 2'b10);
        push("sw_p16",     p + 16, 1'b0, 4'b0000, 1'b0, 2'b10);
        push("sw_b0",      p + 17, 1'b0, 4'b0001, 1'b0, 2'b10);
        push("sw_b1",      p + 21, 1'b0, 4'b0011, 1'b0, 2'b10);
        b1.sw_rst = 1'b1;
        tick_check();
        b1.sw_rst = 1'b0;
        drain();

        // One-cycle external request at RST_OUT=0011: seen after the synchroniser.
        a = ecnt + 1;
        push("ext_a1",     a + 1,  1'b0, 4'b0011, 1'b0, 2'b10);
        push("ext_clr",    a + 2,  1'b0, 4'b0000, 1'b0, 2'b01);
        push("ext_a18",    a + 18, 1'b0, 4'b0000, 1'b0, 2'b01);
        push("ext_b0",     a + 19, 1'b0, 4'b0001, 1'b0, 2'b01);
        push("ext_done",   a + 31, 1'b0, 4'b1111, 1'b1, 2'b01);
        b1.rst_req_n = 1'b0;
        tick_check();
        b1.rst_req_n = 1'b1;
        drain();

        // External and software requests reach the FSM on the same edge.
        c = ecnt + 1;
        push("both_c1",    c + 1,  1'b0, 4'b1111, 1'b1, 2'b01);
        push("both_hit",   c + 2,  1'b0, 4'b0000, 1'b0, 2'b11);
        push("both_hold",  c + 3,  1'b0, 4'b0000, 1'b0, 2'b11);
        push("both_c10",   c + 10, 1'b0, 4'b0000, 1'b0, 2'b11);
        b1.rst_req_n = 1'b0;
        tick_check();
        b1.rst_req_n = 1'b1;
        tick_check();
        b1.sw_rst = 1'b1;
        tick_check();
        b1.sw_rst = 1'b0;
        drain();

        // Master reset in the middle of HOLD.
        push("rst_mid",    ecnt + 1, 1'b0, 4'b0000, 1'b0, 2'b01);
        push("rst_mid_n1", ecnt + 1, 1'b1, 4'b0000, 1'b0, 2'b01);
        rst = 1'b1;
        tick_check();
        rst  = 1'b0;
        ecnt = 0;

        // Restart; a software pulse on edge 1 accumulates into the cause.
        push("acc_e1",     1,  1'b0, 4'b0000, 1'b0, 2'b11);
        push("re_n1_e3",   3,  1'b1, 4'b0000, 1'b0, 2'b01);
        push("re_n1_e4",   4,  1'b1, 4'b0001, 1'b1, 2'b01);
        push("re_e18",    18,  1'b0, 4'b0000, 1'b0, 2'b11);
        push("re_b0",     19,  1'b0, 4'b0001, 1'b0, 2'b11);
        push("re_b1",     23,  1'b0, 4'b0011, 1'b0, 2'b11);
        push("re_b2",     27,  1'b0, 4'b0111, 1'b0, 2'b11);
        push("re_done",   31,  1'b0, 4'b1111, 1'b1, 2'b11);
        b1.sw_rst = 1'b1;
        tick_check();
        b1.sw_rst = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
